sfx_pwm_mixer: RTL

Downstream consumer of the 1-bit square-wave sound generators (jump, death, level-complete, music). Weights each active source, applies optional ducking when the priority source plays, and drives a single PWM line to the board audio pin. All inputs come from the same clock domain. Mix and weight values are recomputed once per PWM frame, so there is no glitching mid-frame.

---
 rtl/sfx_pwm_mixer.sv | 79 +++++++
 1 files changed

// File: rtl/sfx_pwm_mixer.sv
// Weighted mixer for the 1-bit sound sources with optional ducking behind source 0.
// The mix is latched once per PWM frame and drives a single registered PWM audio line.
module sfx_pwm_mixer #(
    parameter int unsigned NUM_SRC  = 4,
    parameter int unsigned WEIGHT_W = 3,
    parameter int unsigned PWM_BITS = 8
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic [NUM_SRC-1:0]           src_in,
    input  logic [NUM_SRC*WEIGHT_W-1:0]  src_weight,
    input  logic                         duck_en,
    input  logic                         mute,
    output logic                         pwm_out,
    output logic                         frame_tick,
    output logic                         busy
);

    localparam int unsigned SUM_W = WEIGHT_W + $clog2(NUM_SRC);
    localparam int unsigned SHIFT = PWM_BITS - SUM_W;
    localparam logic [PWM_BITS-1:0] CNT_MAX = '1;

    logic [PWM_BITS-1:0] pwm_cnt;
    logic [PWM_BITS-1:0] pwm_cnt_next;
    logic [PWM_BITS-1:0] duty_q;
    logic [PWM_BITS-1:0] duty_next;
    logic [SUM_W-1:0]    sum_c;
    logic [WEIGHT_W-1:0] weight_c;
    logic                duck_c;
    logic                frame_wrap_c;

    always_comb begin
        pwm_cnt_next = pwm_cnt + PWM_BITS'(1);
        frame_wrap_c = (pwm_cnt == CNT_MAX);
        duck_c       = duck_en & src_in[0];
    end

    // Sum of active weights; the priority source is never attenuated by ducking.
    always_comb begin
        sum_c    = '0;
        weight_c = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            weight_c = src_weight[i*WEIGHT_W +: WEIGHT_W];
            if (duck_c && (i != 0)) begin
                weight_c = weight_c >> 1;
            end
            if (src_in[i]) begin
                sum_c = sum_c + SUM_W'(weight_c);
            end
        end
    end

    always_comb begin
        duty_next = PWM_BITS'(sum_c) << SHIFT;
        if (mute) begin
            duty_next = '0;
        end
    end

    // Duty and busy only move on the wrap edge so a frame is never altered mid-way.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pwm_cnt    <= '0;
            duty_q     <= '0;
            pwm_out    <= 1'b0;
            frame_tick <= 1'b0;
            busy       <= 1'b0;
        end else begin
            pwm_cnt    <= pwm_cnt_next;
            frame_tick <= (pwm_cnt_next == '0);
            pwm_out    <= (pwm_cnt < duty_q);
            if (frame_wrap_c) begin
                duty_q <= duty_next;
                busy   <= (duty_next != '0);
            end
        end
    end

endmodule
